// File: rtl/bitrev_sequencer.sv
// Sequences the bit-reversal message RAM: collects '0'/'1' characters from RX,
// then streams all MSG_LEN RAM entries to TX in address order.
module bitrev_sequencer #(
  parameter int NBITS   = 8,
  parameter int MSG_LEN = 10,
  parameter int RD_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  input  logic       tx_busy,
  input  logic [7:0] ram_data,
  output logic       ram_wr,
  output logic [3:0] ram_wr_idx,
  output logic       ram_bit,
  output logic [3:0] ram_addr,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  output logic       busy,
  output logic [3:0] bit_count
);

  typedef enum logic [2:0] {COLLECT, LOAD, SEND, GUARD, WAITTX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  addr_q, addr_d;
  logic [3:0]  lat_q, lat_d;
  logic        wr_q, wr_d;
  logic [3:0]  wr_idx_q, wr_idx_d;
  logic        bit_q, bit_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        new_tx_q, new_tx_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    wr_d      = 1'b0;
    wr_idx_d  = wr_idx_q;
    bit_d     = bit_q;
    tx_data_d = tx_data_q;
    new_tx_d  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (new_rx_data && (rx_data == 8'h30 || rx_data == 8'h31)) begin
          wr_d     = 1'b1;
          wr_idx_d = cnt_q[3:0];
          bit_d    = rx_data[0];
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'(NBITS - 1)) begin
            state_d = LOAD;
            addr_d  = '0;
            lat_d   = '0;
          end
        end
      end
      LOAD: begin
        // address must sit still long enough for the registered RAM read
        if (lat_q == 4'(RD_LAT - 1)) state_d = SEND;
        else                         lat_d   = lat_q + 4'd1;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d = ram_data;
          new_tx_d  = 1'b1;
          state_d   = GUARD;
        end
      end
      // TX raises busy a cycle after the strobe, so skip one cycle before looking
      GUARD: state_d = WAITTX;
      WAITTX: begin
        if (!tx_busy) begin
          if (addr_q == 4'(MSG_LEN - 1)) begin
            addr_d  = '0;
            cnt_d   = '0;
            state_d = COLLECT;
          end else begin
            addr_d  = addr_q + 4'd1;
            lat_d   = '0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    // rises the cycle after the final write, drops as COLLECT is re-entered
    busy_d = (state_q != COLLECT) && (state_d != COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      addr_q    <= '0;
      lat_q     <= '0;
      wr_q      <= 1'b0;
      wr_idx_q  <= '0;
      bit_q     <= 1'b0;
      tx_data_q <= '0;
      new_tx_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      wr_q      <= wr_d;
      wr_idx_q  <= wr_idx_d;
      bit_q     <= bit_d;
      tx_data_q <= tx_data_d;
      new_tx_q  <= new_tx_d;
      busy_q    <= busy_d;
    end
  end

  assign ram_wr      = wr_q;
  assign ram_wr_idx  = wr_idx_q;
  assign ram_bit     = bit_q;
  assign ram_addr    = addr_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign busy        = busy_q;
  assign bit_count   = cnt_q[3:0];

endmodule
